// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring signed divide/remainder.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1000;
  localparam logic [3:0] OP_REM = 4'b1001;

  localparam logic [SHW:0] CNT_LOAD = WIDTH[SHW:0];
  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0] CNT_ZERO = '0;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [1:0]       r_state;
  logic [SHW:0]     r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_acc;
  logic             r_qneg;
  logic             r_rneg;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_div0;
  logic             w_ovf;
  logic             w_iter;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_fast;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_iter_res;

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);
  assign busy_o  = (r_state == S_BUSY);
  assign data_o  = r_data;

  assign w_is_mul = (ALUCtrl_i == OP_MUL);
  assign w_is_div = (ALUCtrl_i == OP_DIV) || (ALUCtrl_i == OP_REM);
  assign w_div0   = (data1_i == ZERO);
  assign w_ovf    = (data0_i == MIN_NEG) && (data1_i == ALL_ONES);
  assign w_iter   = w_is_mul || (w_is_div && !w_div0 && !w_ovf);
  assign w_shamt  = data1_i[SHW-1:0];

  assign w_sa   = data0_i[WIDTH-1];
  assign w_sb   = data1_i[WIDTH-1];
  assign w_amag = w_sa ? -data0_i : data0_i;
  assign w_bmag = w_sb ? -data1_i : data1_i;

  always_comb begin
    w_fast = data0_i;
    unique case (ALUCtrl_i)
      OP_AND: w_fast = data0_i & data1_i;
      OP_XOR: w_fast = data0_i ^ data1_i;
      OP_SLL: w_fast = data0_i << w_shamt;
      OP_ADD: w_fast = data0_i + data1_i;
      OP_SUB: w_fast = data0_i - data1_i;
      OP_SRA: w_fast = $signed(data0_i) >>> w_shamt;
      OP_DIV: w_fast = w_div0 ? ALL_ONES : data0_i;
      OP_REM: w_fast = w_div0 ? data0_i : ZERO;
      default: w_fast = data0_i;
    endcase
  end

  // MUL: r_x multiplicand, r_y multiplier, r_acc product.
  // DIV: r_x dividend shifting into quotient, r_y divisor, r_acc remainder.
  assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
  assign w_rem_sh  = {r_acc, r_x[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_y};
  assign w_fits    = !w_diff[WIDTH];
  assign w_rem_nx  = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx  = {r_x[WIDTH-2:0], w_fits};
  assign w_quo_fix = r_qneg ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_rneg ? -w_rem_nx : w_rem_nx;

  always_comb begin
    w_iter_res = w_rem_fix;
    if (r_op == OP_MUL) begin
      w_iter_res = w_mul_acc;
    end else if (r_op == OP_DIV) begin
      w_iter_res = w_quo_fix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_op    <= OP_AND;
      r_data  <= ZERO;
      r_x     <= ZERO;
      r_y     <= ZERO;
      r_acc   <= ZERO;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op <= ALUCtrl_i;
            if (w_iter) begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_LOAD;
              r_acc   <= ZERO;
              r_qneg  <= w_sa ^ w_sb;
              r_rneg  <= w_sa;
              r_x     <= w_is_mul ? data0_i : w_amag;
              r_y     <= w_is_mul ? data1_i : w_bmag;
            end else begin
              r_state <= S_DONE;
              r_data  <= w_fast;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_acc;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end else begin
            r_acc <= w_rem_nx;
            r_x   <= w_quo_nx;
          end
          if (r_cnt == CNT_ONE) begin
            r_state <= S_DONE;
            r_data  <= w_iter_res;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: WIDTH=32 main instance plus a WIDTH=8
// instance; a negedge monitor pops expected results on each valid_o rise.
module tb_seq_alu;

  typedef struct {
    logic [31:0] d;
    int          c;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vi;
  logic        ri;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ro;
  logic        vo;
  logic        bo;
  logic [31:0] d;

  logic        rst8;
  logic        vi8;
  logic        ri8;
  logic [3:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        ro8;
  logic        vo8;
  logic        bo8;
  logic [7:0]  d8;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic pv     = 1'b0;
  logic pv8    = 1'b0;
  exp_t sb[$];
  exp_t sb8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vi), .ready_o(ro),
    .ALUCtrl_i(op), .data0_i(a), .data1_i(b), .valid_o(vo),
    .ready_i(ri), .data_o(d), .busy_o(bo)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst8), .valid_i(vi8), .ready_o(ro8),
    .ALUCtrl_i(op8), .data0_i(a8), .data1_i(b8), .valid_o(vo8),
    .ready_i(ri8), .data_o(d8), .busy_o(bo8)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vo && !pv) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid32", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_data"}, d, e.d);
        chk({e.nm, "_cycle"}, cyc, e.c);
      end
    end
    pv = vo;
    if (vo8 && !pv8) begin
      if (sb8.size() == 0) begin
        chk("unexpected_valid8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        chk({e.nm, "_data"}, {24'd0, d8}, e.d);
        chk({e.nm, "_cycle"}, cyc, e.c);
      end
    end
    pv8 = vo8;
  end

  task automatic issue(input string nm, input logic [3:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat);
    exp_t t;
    int   n;
    op = o;
    a  = x;
    b  = y;
    vi = 1'b1;
    n  = 0;
    while (!ro && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ro) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    t.d  = e;
    t.c  = cyc + lat;
    t.nm = nm;
    sb.push_back(t);
    @(posedge clk);
    #1;
    vi = 1'b0;
    op = 4'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic run(input string nm, input logic [3:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e, input int lat);
    int nb;
    int n;
    issue(nm, o, x, y, e, lat);
    chk({nm, "_rdy_low"}, {31'd0, ro}, 32'd0);
    nb = 0;
    n  = 0;
    while (n < 200) begin
      @(negedge clk);
      if (vo) break;
      if (bo) nb++;
      n++;
    end
    if (!vo) chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
    chk({nm, "_busy_cycles"}, nb, lat - 1);
    @(posedge clk);
    #1;
    chk({nm, "_idle_back"}, {30'd0, ro, vo}, 32'd2);
  endtask

  task automatic run8(input string nm, input logic [3:0] o,
                      input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] e, input int lat);
    exp_t t;
    int   n;
    op8 = o;
    a8  = x;
    b8  = y;
    vi8 = 1'b1;
    t.d  = {24'd0, e};
    t.c  = cyc + lat;
    t.nm = nm;
    sb8.push_back(t);
    @(posedge clk);
    #1;
    vi8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    n   = 0;
    while (!vo8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!vo8) chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; vi = 1'b0; ri = 1'b1; op = '0; a = '0; b = '0;
    rst8 = 1'b1; vi8 = 1'b0; ri8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst8 = 1'b0;
    chk("reset_state", {28'd0, ro, vo, bo, 1'b0}, 32'h8);
    chk("reset_data", d, 32'h0);

    run("add_wrap", 4'b0011, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
    run("sra_neg",  4'b0111, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run("sll_31",   4'b0010, 32'h1, 32'd31, 32'h8000_0000, 1);
    run("and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    run("xor",      4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    run("sub_wrap", 4'b0100, 32'h0, 32'h1, 32'hFFFF_FFFF, 1);
    run("undef_op", 4'b0110, 32'h1234_5678, 32'h9, 32'h1234_5678, 1);
    run("mul_m1x3", 4'b0101, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD, 33);
    run("mul_pos",  4'b0101, 32'h0001_2345, 32'h100, 32'h0123_4500, 33);
    run("mul_negs", 4'b0101, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'd35, 33);
    run("div_m7_2", 4'b1000, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
    run("rem_m7_2", 4'b1001, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
    run("div_100_7", 4'b1000, 32'd100, 32'd7, 32'd14, 33);
    run("rem_100_7", 4'b1001, 32'd100, 32'd7, 32'd2, 33);
    run("div_7_m2", 4'b1000, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run("rem_7_m2", 4'b1001, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run("div_m8_m3", 4'b1000, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 33);
    run("rem_m8_m3", 4'b1001, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33);
    run("div_by0",  4'b1000, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0",  4'b1001, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf",  4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",  4'b1001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // consumer stall: result must hold while stray requests are ignored
    ri = 1'b0;
    issue("stall", 4'b0001, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555, 1);
    for (int i = 0; i < 5; i++) begin
      vi = i[0];
      op = 4'b0011;
      a  = 32'h1;
      b  = 32'h1;
      @(negedge clk);
      chk("stall_hold", {d[31:1], vo}, {31'h5555_2AAA, 1'b1});
    end
    vi = 1'b0;
    ri = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", {30'd0, ro, vo}, 32'd2);
    repeat (3) @(negedge clk);
    chk("stall_no_extra", {31'd0, vo}, 32'd0);

    // reset abandons a DIV in flight
    issue("div_rst", 4'b1000, 32'd100, 32'd7, 32'd14, 33);
    void'(sb.pop_back());
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_rst", {31'd0, bo}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy", {28'd0, ro, vo, bo, 1'b0}, 32'h8);
    chk("rst_mid_data", d, 32'h0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (vo) seen++;
    end
    chk("rst_no_valid", seen, 0);

    // reset wins over a simultaneous request
    rst = 1'b1;
    vi  = 1'b1;
    op  = 4'b0011;
    a   = 32'h5;
    b   = 32'h6;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vi  = 1'b0;
    chk("rst_vs_accept", {28'd0, ro, vo, bo, 1'b0}, 32'h8);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (vo || bo) seen++;
    end
    chk("rst_no_accept", seen, 0);

    run8("w8_mul",   4'b0101, 8'h10, 8'h10, 8'h00, 9);
    run8("w8_undef", 4'b1111, 8'hA5, 8'h3C, 8'hA5, 1);
    run8("w8_add",   4'b0011, 8'h7F, 8'h01, 8'h80, 1);
    run8("w8_ovf",   4'b1000, 8'h80, 8'hFF, 8'h80, 1);
    run8("w8_div",   4'b1000, 8'hF9, 8'h02, 8'hFD, 9);
    run8("w8_sra",   4'b0111, 8'h80, 8'h0B, 8'hF0, 1);

    repeat (3) @(negedge clk);
    chk("sb32_empty", sb.size(), 0);
    chk("sb8_empty", sb8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
